// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard at the ID->EX issue point: per-register wait timers and
// result ages produce the issue stall and the forwarding-source select for each operand.
module hazard_scoreboard #(
  parameter  int NREGS       = 32,
  parameter  int MAX_LATENCY = 4,
  parameter  int FWD_DEPTH   = 2,
  localparam int RA_W        = $clog2(NREGS),
  localparam int LAT_W       = $clog2(MAX_LATENCY + 1),
  localparam int SEL_W       = $clog2(FWD_DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_regwrite,
  input  logic [RA_W-1:0]  issue_rd,
  input  logic [LAT_W-1:0] issue_latency,
  input  logic [RA_W-1:0]  issue_rs1,
  input  logic [RA_W-1:0]  issue_rs2,
  input  logic             issue_rs1_used,
  input  logic             issue_rs2_used,
  input  logic             flush,
  output logic             issue_ready,
  output logic             issue_fire,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_sel_rs1,
  output logic [SEL_W-1:0] fwd_sel_rs2,
  output logic [NREGS-1:0] busy_mask
);

  localparam logic [SEL_W-1:0] AGE_MAX = SEL_W'(FWD_DEPTH + 1);
  localparam logic [SEL_W-1:0] AGE_FWD = SEL_W'(FWD_DEPTH);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LATENCY);

  logic [LAT_W-1:0] r_t      [NREGS];
  logic [SEL_W-1:0] r_a      [NREGS];
  logic [LAT_W-1:0] w_t_next [NREGS];
  logic [SEL_W-1:0] w_a_next [NREGS];

  logic             w_haz_rs1;
  logic             w_haz_rs2;
  logic             w_write;
  logic [LAT_W-1:0] w_lat;

  // An age inside 1..FWD_DEPTH names the post-EX register holding the youngest value.
  function automatic logic [SEL_W-1:0] pick_sel(input logic            used,
                                                input logic [RA_W-1:0] rs,
                                                input logic [SEL_W-1:0] age);
    logic [SEL_W-1:0] sel;
    sel = '0;
    if (used && (rs != '0) && (age != '0) && (age <= AGE_FWD)) begin
      sel = age;
    end
    return sel;
  endfunction

  always_comb begin
    w_haz_rs1   = issue_rs1_used && (issue_rs1 != '0) && (r_t[issue_rs1] != '0);
    w_haz_rs2   = issue_rs2_used && (issue_rs2 != '0) && (r_t[issue_rs2] != '0);
    fwd_sel_rs1 = pick_sel(issue_rs1_used, issue_rs1, r_a[issue_rs1]);
    fwd_sel_rs2 = pick_sel(issue_rs2_used, issue_rs2, r_a[issue_rs2]);
  end

  assign issue_ready = !w_haz_rs1 && !w_haz_rs2;
  assign issue_fire  = issue_valid && issue_ready && !flush;
  assign stall       = issue_valid && !issue_ready && !flush;
  assign w_write     = issue_fire && issue_regwrite && (issue_rd != '0);

  always_comb begin
    w_lat = issue_latency;
    if (issue_latency == '0) begin
      w_lat = LAT_W'(1);
    end else if (issue_latency > LAT_MAX) begin
      w_lat = LAT_MAX;
    end
  end

  // A fresh write replaces the entry outright, so WAW always tracks the youngest producer.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_t_next[r] = (r_t[r] != '0) ? (r_t[r] - LAT_W'(1)) : '0;
      w_a_next[r] = (r_a[r] == AGE_MAX) ? AGE_MAX : (r_a[r] + SEL_W'(1));
      if (r == 0) begin
        w_t_next[r] = '0;
        w_a_next[r] = AGE_MAX;
      end else if (w_write && (issue_rd == RA_W'(r))) begin
        w_t_next[r] = w_lat - LAT_W'(1);
        w_a_next[r] = SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (rst) begin
        r_t[r] <= '0;
        r_a[r] <= AGE_MAX;
      end else begin
        r_t[r] <= w_t_next[r];
        r_a[r] <= w_a_next[r];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
      assign busy_mask[gi] = (r_t[gi] != '0);
    end
  endgenerate

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic, checked against a
// model that records each register's youngest producer issue cycle and latency.
module tb_hazard_scoreboard;

  localparam int NREGS       = 32;
  localparam int MAX_LATENCY = 4;
  localparam int FWD_DEPTH   = 2;
  localparam int RA_W        = 5;
  localparam int LAT_W       = 3;
  localparam int SEL_W       = 2;
  localparam int NEVER       = -1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid, issue_regwrite;
  logic [RA_W-1:0]  issue_rd, issue_rs1, issue_rs2;
  logic [LAT_W-1:0] issue_latency;
  logic             issue_rs1_used, issue_rs2_used, flush;
  logic             issue_ready, issue_fire, stall;
  logic [SEL_W-1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic [NREGS-1:0] busy_mask;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREGS(NREGS), .MAX_LATENCY(MAX_LATENCY), .FWD_DEPTH(FWD_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_rd(issue_rd), .issue_latency(issue_latency),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .flush(flush),
    .issue_ready(issue_ready), .issue_fire(issue_fire), .stall(stall),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .busy_mask(busy_mask)
  );

  // model: issue cycle and clamped latency of the youngest producer per register
  int fire_cyc [NREGS];
  int lat_m    [NREGS];
  int cyc;
  int n_checks = 0;
  int n_pass   = 0;

  logic             o_ready, o_fire, o_stall;
  logic [SEL_W-1:0] o_sel1, o_sel2;
  logic [NREGS-1:0] o_busy;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit pending(input int r);
    return (r != 0) && ((cyc - fire_cyc[r]) < lat_m[r]);
  endfunction

  function automatic int exp_sel(input int rs, input bit used);
    int n;
    if (!used || rs == 0) return 0;
    n = cyc - fire_cyc[rs];
    return (n >= 1 && n <= FWD_DEPTH) ? n : 0;
  endfunction

  function automatic int clamp_lat(input int l);
    if (l == 0) return 1;
    if (l > MAX_LATENCY) return MAX_LATENCY;
    return l;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < NREGS; r++) begin
      fire_cyc[r] = NEVER;
      lat_m[r]    = 0;
    end
  endtask

  task automatic step(input bit v, input bit wr, input int rd, input int lat,
                      input int rs1, input bit u1, input int rs2, input bit u2,
                      input bit fl, input bit r_in);
    bit               e_ready;
    logic [NREGS-1:0] e_busy;
    issue_valid    = v;
    issue_regwrite = wr;
    issue_rd       = RA_W'(rd);
    issue_latency  = LAT_W'(lat);
    issue_rs1      = RA_W'(rs1);
    issue_rs1_used = u1;
    issue_rs2      = RA_W'(rs2);
    issue_rs2_used = u2;
    flush          = fl;
    rst            = r_in;
    @(negedge clk);
    o_ready = issue_ready; o_fire = issue_fire; o_stall = stall;
    o_sel1  = fwd_sel_rs1; o_sel2 = fwd_sel_rs2; o_busy = busy_mask;
    e_ready = !(u1 && pending(rs1)) && !(u2 && pending(rs2));
    for (int r = 0; r < NREGS; r++) e_busy[r] = pending(r);
    check_eq("ready", o_ready, e_ready);
    check_eq("fire", o_fire, v && e_ready && !fl);
    check_eq("stall", o_stall, v && !e_ready && !fl);
    check_eq("busy_mask", o_busy, e_busy);
    if (e_ready) begin
      check_eq("sel_rs1", o_sel1, exp_sel(rs1, u1));
      check_eq("sel_rs2", o_sel2, exp_sel(rs2, u2));
    end
    $display("cyc %0d v=%0b wr=%0b rd=%0d L=%0d rs1=%0d/%0b rs2=%0d/%0b fl=%0b rst=%0b -> rdy=%0b fire=%0b stall=%0b sel=%0d/%0d busy=%h",
             cyc, v, wr, rd, lat, rs1, u1, rs2, u2, fl, r_in,
             o_ready, o_fire, o_stall, o_sel1, o_sel2, o_busy);
    @(posedge clk);
    if (r_in) clear_model();
    else if (v && e_ready && !fl && wr && rd != 0) begin
      fire_cyc[rd] = cyc;
      lat_m[rd]    = clamp_lat(lat);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int stalls;

  initial begin
    clear_model();
    cyc = 0;
    issue_valid = 0; issue_regwrite = 0; issue_rd = '0; issue_latency = '0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rs1_used = 0; issue_rs2_used = 0; flush = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;

    // reset state: all sources readable, nothing busy
    step(1, 0, 0, 0, 3, 1, 4, 1, 0, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_sel1", o_sel1, 0);
    check_eq("rst_sel2", o_sel2, 0);

    // back-to-back ALU
    step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 5, 1, 0, 0, 0, 0);
    check_eq("b2b_ready", o_ready, 1);
    check_eq("b2b_sel1", o_sel1, 1);
    idle(5);

    // load-use
    step(1, 1, 6, 2, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 6, 1, 0, 0, 0, 0);
    check_eq("lu_stall", o_stall, 1);
    step(1, 0, 0, 1, 6, 1, 0, 0, 0, 0);
    check_eq("lu_fire", o_fire, 1);
    check_eq("lu_sel1", o_sel1, 2);
    idle(5);

    // long latency on rs2
    step(1, 1, 7, 4, 0, 0, 0, 0, 0, 0);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 1, 0, 0, 7, 1, 0, 0);
      if (o_fire) break;
      stalls++;
    end
    check_eq("long_stalls", stalls, 3);
    check_eq("long_sel2", o_sel2, 0);
    idle(5);

    // x0 producer/consumer and unused source
    step(1, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    check_eq("x0_stall", o_stall, 0);
    check_eq("x0_sel1", o_sel1, 0);
    step(1, 1, 11, 4, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 11, 0, 0, 0, 0, 0);
    check_eq("unused_stall", o_stall, 0);
    idle(5);

    // flushed producer leaves no trace
    step(1, 1, 8, 3, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("flush_busy8", o_busy[8], 0);
    idle(4);

    // WAW: younger ALU write hides older load
    step(1, 1, 9, 3, 0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 9, 1, 0, 0, 0, 0);
    check_eq("waw_stall", o_stall, 0);
    check_eq("waw_sel1", o_sel1, 1);
    idle(5);

    // reset mid-flight
    step(1, 1, 10, 4, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 10, 1, 0, 0, 0, 0);
    check_eq("rstmid_busy", o_busy, 0);
    check_eq("rstmid_fire", o_fire, 1);
    check_eq("rstmid_sel1", o_sel1, 0);

    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
